// File: rtl/mips_pipe_pkg.sv
// Shared widths and the MEM/WB payload record
// for the 16-bit MIPS pipeline.
package mips_pipe_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_REG_ADDR_W = 3;

  typedef struct packed {
    logic                      memtoreg;
    logic [DEF_DATA_W-1:0]     readdata;
    logic [DEF_DATA_W-1:0]     aluresult;
    logic [DEF_REG_ADDR_W-1:0] wreg;
    logic                      regwrite;
  } mem_wb_t;

  function automatic int mem_wb_bits(
    input int dw,
    input int aw
  );
    return 2 * dw + aw + 2;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with an
// optional one-entry skid buffer and flush.
module pipe_skid_reg #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid;
  logic [W-1:0] main_data;
  logic         in_fire;
  logic         drain;

  assign in_fire   = in_valid & in_ready;
  assign drain     = ~main_valid | out_ready;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  generate
    if (SKID_EN) begin : g_skid
      logic         skid_valid;
      logic [W-1:0] skid_data;

      // ready comes straight from a flop: no
      // combinational path from out_ready
      assign in_ready = ~skid_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (drain) begin
          if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= in_fire;
            if (in_fire) begin
              skid_data <= in_data;
            end
          end else begin
            main_valid <= in_fire;
            if (in_fire) begin
              main_data <= in_data;
            end
          end
        end else if (in_fire) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end else begin : g_plain
      assign in_ready = drain;

      always_ff @(posedge clk) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (drain) begin
          main_valid <= in_fire;
          if (in_fire) begin
            main_data <= in_data;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB stage: registers the writeback payload,
// selects write data and masks R0 forwarding.
module mem_wb_pipe
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter bit SKID_EN    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_MemtoReg,
  input  logic [DATA_W-1:0]     in_ReadData,
  input  logic [DATA_W-1:0]     in_ALUResult,
  input  logic [REG_ADDR_W-1:0] in_WriteRegister,
  input  logic                  in_RegWrite,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  O_RegWrite,
  output logic [REG_ADDR_W-1:0] O_WriteRegister,
  output logic [DATA_W-1:0]     O_WriteData,
  output logic                  O_MemtoReg,
  output logic [DATA_W-1:0]     O_ReadData,
  output logic [DATA_W-1:0]     O_ALUResult,
  output logic                  fwd_valid
);

  localparam int PW = mem_wb_bits(DATA_W, REG_ADDR_W);

  typedef struct packed {
    logic                  memtoreg;
    logic [DATA_W-1:0]     readdata;
    logic [DATA_W-1:0]     aluresult;
    logic [REG_ADDR_W-1:0] wreg;
    logic                  regwrite;
  } payload_t;

  payload_t in_p;
  payload_t out_p;

  assign in_p = '{
    memtoreg:  in_MemtoReg,
    readdata:  in_ReadData,
    aluresult: in_ALUResult,
    wreg:      in_WriteRegister,
    regwrite:  in_RegWrite
  };

  pipe_skid_reg #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_p),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_p)
  );

  assign O_MemtoReg      = out_p.memtoreg;
  assign O_ReadData      = out_p.readdata;
  assign O_ALUResult     = out_p.aluresult;
  assign O_WriteRegister = out_p.wreg;
  assign O_WriteData     = out_p.memtoreg ? out_p.readdata
                                          : out_p.aluresult;
  // stale fields must never look like a write
  assign O_RegWrite      = out_p.regwrite & out_valid;
  assign fwd_valid       = O_RegWrite & (out_p.wreg != '0);

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe (SKID_EN=1):
// vector table, scoreboard and corner sequences.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_MemtoReg;
  logic [15:0] in_ReadData;
  logic [15:0] in_ALUResult;
  logic [2:0]  in_WriteRegister;
  logic        in_RegWrite;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic        O_RegWrite;
  logic [2:0]  O_WriteRegister;
  logic [15:0] O_WriteData;
  logic        O_MemtoReg;
  logic [15:0] O_ReadData;
  logic [15:0] O_ALUResult;
  logic        fwd_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(
    .DATA_W     (16),
    .REG_ADDR_W (3),
    .SKID_EN    (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_MemtoReg      (in_MemtoReg),
    .in_ReadData      (in_ReadData),
    .in_ALUResult     (in_ALUResult),
    .in_WriteRegister (in_WriteRegister),
    .in_RegWrite      (in_RegWrite),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .O_RegWrite       (O_RegWrite),
    .O_WriteRegister  (O_WriteRegister),
    .O_WriteData      (O_WriteData),
    .O_MemtoReg       (O_MemtoReg),
    .O_ReadData       (O_ReadData),
    .O_ALUResult      (O_ALUResult),
    .fwd_valid        (fwd_valid)
  );

  typedef struct {
    logic [15:0] wdata;
    logic [2:0]  wreg;
    logic        regwrite;
    logic        fwd;
  } exp_t;

  typedef struct {
    logic        m2r;
    logic [15:0] rd;
    logic [15:0] alu;
    logic [2:0]  wreg;
    logic        rw;
    logic [15:0] exp_wdata;
    logic        exp_fwd;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  exp_t n;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic        m2r,
    input logic [15:0] rd,
    input logic [15:0] alu,
    input logic [2:0]  wr,
    input logic        rw
  );
    in_valid         = v;
    in_MemtoReg      = m2r;
    in_ReadData      = rd;
    in_ALUResult     = alu;
    in_WriteRegister = wr;
    in_RegWrite      = rw;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pop on output handshake, push
  // on input handshake (both about to fire)
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_wdata", 32'(O_WriteData), 32'(e.wdata));
          chk("sb_wreg", 32'(O_WriteRegister), 32'(e.wreg));
          chk("sb_regwrite", 32'(O_RegWrite), 32'(e.regwrite));
          chk("sb_fwd", 32'(fwd_valid), 32'(e.fwd));
        end
      end
      if (in_valid && in_ready) begin
        n.wdata    = in_MemtoReg ? in_ReadData : in_ALUResult;
        n.wreg     = in_WriteRegister;
        n.regwrite = in_RegWrite;
        n.fwd      = in_RegWrite && (in_WriteRegister != 3'd0);
        sb.push_back(n);
      end
    end
  end

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b0, 16'h5555, 16'h0001, 3'd1, 1'b1, 16'h0001, 1'b1};
    vecs[1] = '{1'b0, 16'h5555, 16'h0002, 3'd2, 1'b1, 16'h0002, 1'b1};
    vecs[2] = '{1'b0, 16'h5555, 16'h0003, 3'd3, 1'b1, 16'h0003, 1'b1};
    vecs[3] = '{1'b1, 16'hBEEF, 16'h0010, 3'd7, 1'b1, 16'hBEEF, 1'b1};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h8000, 3'd4, 1'b0, 16'h8000, 1'b0};
    vecs[5] = '{1'b1, 16'h00C3, 16'h1111, 3'd0, 1'b1, 16'h00C3, 1'b0};

    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_wdata", 32'(O_WriteData), 32'd0);
    chk("rst_wreg", 32'(O_WriteRegister), 32'd0);
    chk("rst_regwrite", 32'(O_RegWrite), 32'd0);
    chk("rst_fwd", 32'(fwd_valid), 32'd0);

    // single load
    next_cycle();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h1234, 16'h00F0, 3'd5, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    @(negedge clk);
    chk("ld_out_valid", 32'(out_valid), 32'd1);
    chk("ld_wdata", 32'(O_WriteData), 32'h1234);
    chk("ld_wreg", 32'(O_WriteRegister), 32'd5);
    chk("ld_regwrite", 32'(O_RegWrite), 32'd1);
    chk("ld_fwd", 32'(fwd_valid), 32'd1);

    // back-to-back table
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(1'b1, vecs[i].m2r, vecs[i].rd, vecs[i].alu,
            vecs[i].wreg, vecs[i].rw);
      @(negedge clk);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("vec%0d_prev_wdata", i),
            32'(O_WriteData), 32'(vecs[i-1].exp_wdata));
        chk($sformatf("vec%0d_prev_fwd", i),
            32'(fwd_valid), 32'(vecs[i-1].exp_fwd));
      end
    end
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    repeat (2) next_cycle();

    // backpressure into skid
    drive(1'b1, 1'b0, 16'h0, 16'hAAAA, 3'd1, 1'b1);
    next_cycle();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0, 16'hBBBB, 3'd2, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_a", 32'(O_WriteData), 32'hAAAA);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_a", 32'(O_WriteData), 32'hAAAA);
    next_cycle();
    @(negedge clk);
    chk("bp_rel_b", 32'(O_WriteData), 32'hBBBB);
    chk("bp_b_valid", 32'(out_valid), 32'd1);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'd0);

    // flush with main and skid full plus input C
    next_cycle();
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0, 16'h0D01, 3'd3, 1'b1);
    next_cycle();
    drive(1'b1, 1'b0, 16'h0, 16'h0D02, 3'd4, 1'b1);
    next_cycle();
    flush = 1'b1;
    drive(1'b1, 1'b0, 16'h0, 16'h0CCC, 3'd6, 1'b1);
    @(negedge clk);
    chk("fl_skid_full", 32'(in_ready), 32'd0);
    next_cycle();
    flush = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    @(negedge clk);
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_regwrite", 32'(O_RegWrite), 32'd0);
    next_cycle();
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fl_no_c", 32'(out_valid), 32'd0);
      next_cycle();
    end

    // write to R0 then bubble
    drive(1'b1, 1'b0, 16'h0, 16'h7FFF, 3'd0, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    @(negedge clk);
    chk("r0_regwrite", 32'(O_RegWrite), 32'd1);
    chk("r0_fwd", 32'(fwd_valid), 32'd0);
    chk("r0_wdata", 32'(O_WriteData), 32'h7FFF);
    next_cycle();
    @(negedge clk);
    chk("bub_out_valid", 32'(out_valid), 32'd0);
    chk("bub_regwrite", 32'(O_RegWrite), 32'd0);
    chk("bub_stale_alu", 32'(O_ALUResult), 32'h7FFF);
    chk("bub_stale_wdata", 32'(O_WriteData), 32'h7FFF);

    // reset mid-traffic
    next_cycle();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 16'h4242, 16'h0, 3'd2, 1'b1);
    next_cycle();
    drive(1'b1, 1'b1, 16'h4343, 16'h0, 3'd3, 1'b1);
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    chk("mr_wdata", 32'(O_WriteData), 32'd0);
    chk("mr_rdata", 32'(O_ReadData), 32'd0);
    chk("mr_memtoreg", 32'(O_MemtoReg), 32'd0);
    next_cycle();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h9A9A, 16'h0001, 3'd6, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    @(negedge clk);
    chk("mr_after_valid", 32'(out_valid), 32'd1);
    chk("mr_after_wdata", 32'(O_WriteData), 32'h9A9A);
    repeat (2) next_cycle();

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
